// File: rtl/ws_tile_controller.sv
// Weight-stationary tile sequencer for a systolic array.
// For each weight tile it streams ARRAY_COLS weight loads, then a skewed
// compute window that feeds iact columns and drains psum rows. A stall
// freezes progress and masks every strobe for that cycle.
module ws_tile_controller #(
   parameter int ARRAY_ROWS = 3,
   parameter int ARRAY_COLS = 3,
   parameter int ADDR_W     = 32,
   parameter int CNT_W      = 16
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  go,
   input  logic [CNT_W-1:0]      iact_cols,
   input  logic [CNT_W-1:0]      num_tiles,
   input  logic [ADDR_W-1:0]     weight_base,
   input  logic [ADDR_W-1:0]     iact_base,
   input  logic [ADDR_W-1:0]     psum_base,
   input  logic                  stall,
   output logic                  busy,
   output logic                  load_weight,
   output logic [ADDR_W-1:0]     weight_addr,
   output logic [ARRAY_COLS-1:0] load_iact,
   output logic [ADDR_W-1:0]     iact_addr [ARRAY_COLS],
   output logic [ARRAY_ROWS-1:0] psum_valid,
   output logic [ADDR_W-1:0]     psum_addr [ARRAY_ROWS],
   output logic                  accumulate,
   output logic [CNT_W-1:0]      tile_idx,
   output logic                  done
);

   localparam logic [1:0] S_IDLE    = 2'd0;
   localparam logic [1:0] S_LOAD_W  = 2'd1;
   localparam logic [1:0] S_COMPUTE = 2'd2;
   localparam logic [1:0] S_DONE    = 2'd3;

   // Counter must reach iact_cols + ARRAY_ROWS + ARRAY_COLS - 1 without wrapping.
   localparam int C_W = CNT_W + $clog2(ARRAY_ROWS + ARRAY_COLS + 1) + 1;

   logic [1:0]        state_reg;
   logic [C_W-1:0]    cnt_reg;
   logic [CNT_W-1:0]  tile_reg;
   logic [CNT_W-1:0]  cols_reg;
   logic [CNT_W-1:0]  tiles_reg;
   logic [ADDR_W-1:0] wbase_reg;
   logic [ADDR_W-1:0] ibase_reg;
   logic [ADDR_W-1:0] pbase_reg;

   logic              w_last;
   logic              c_last;
   logic              tile_last;
   logic              in_load;
   logic              in_comp;
   logic [ADDR_W-1:0] cnt_a;
   logic [ADDR_W-1:0] cols_a;

   assign w_last    = (cnt_reg == C_W'(ARRAY_COLS - 1));
   assign c_last    = (cnt_reg == C_W'(cols_reg) + C_W'(ARRAY_ROWS + ARRAY_COLS - 1));
   assign tile_last = (tile_reg == tiles_reg - CNT_W'(1));
   assign in_load   = (state_reg == S_LOAD_W);
   assign in_comp   = (state_reg == S_COMPUTE);
   assign cnt_a     = ADDR_W'(cnt_reg);
   assign cols_a    = ADDR_W'(cols_reg);

   // Sequencer: config latch, phase counter and tile progression.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_reg <= S_IDLE;
         cnt_reg   <= '0;
         tile_reg  <= '0;
         cols_reg  <= '0;
         tiles_reg <= '0;
         wbase_reg <= '0;
         ibase_reg <= '0;
         pbase_reg <= '0;
      end else begin
         case (state_reg)
            S_IDLE: begin
               if (go) begin
                  cols_reg  <= iact_cols;
                  tiles_reg <= num_tiles;
                  wbase_reg <= weight_base;
                  ibase_reg <= iact_base;
                  pbase_reg <= psum_base;
                  tile_reg  <= '0;
                  cnt_reg   <= '0;
                  // An empty problem skips straight to the completion pulse.
                  state_reg <= (iact_cols == '0 || num_tiles == '0) ? S_DONE : S_LOAD_W;
               end
            end
            S_LOAD_W: begin
               if (!stall) begin
                  if (w_last) begin
                     cnt_reg   <= '0;
                     state_reg <= S_COMPUTE;
                  end else begin
                     cnt_reg <= cnt_reg + C_W'(1);
                  end
               end
            end
            S_COMPUTE: begin
               if (!stall) begin
                  if (c_last) begin
                     cnt_reg <= '0;
                     if (tile_last) begin
                        state_reg <= S_DONE;
                     end else begin
                        tile_reg  <= tile_reg + CNT_W'(1);
                        state_reg <= S_LOAD_W;
                     end
                  end else begin
                     cnt_reg <= cnt_reg + C_W'(1);
                  end
               end
            end
            default: state_reg <= S_IDLE;
         endcase
      end
   end

   // Status outputs decoded from the current state.
   always_comb begin
      busy        = (state_reg != S_IDLE);
      done        = (state_reg == S_DONE);
      accumulate  = busy && (tile_reg != '0);
      tile_idx    = tile_reg;
      load_weight = in_load && !stall;
      weight_addr = in_load ? (wbase_reg + ADDR_W'(tile_reg) * ADDR_W'(ARRAY_COLS) + cnt_a) : '0;
   end

   // Column j sees its iact stream skewed by j cycles.
   generate
      for (genvar gi = 0; gi < ARRAY_COLS; gi++) begin : g_iact
         logic win;
         assign win = in_comp && (cnt_reg >= C_W'(gi)) &&
                      (cnt_reg < C_W'(gi) + C_W'(cols_reg));
         assign load_iact[gi] = win && !stall;
         assign iact_addr[gi] = win ? (ibase_reg + ADDR_W'(gi) * cols_a + cnt_a - ADDR_W'(gi)) : '0;
      end
   endgenerate

   // Row i drains once the skewed data has crossed all columns.
   generate
      for (genvar gi = 0; gi < ARRAY_ROWS; gi++) begin : g_psum
         logic win;
         assign win = in_comp && (cnt_reg >= C_W'(ARRAY_COLS + gi)) &&
                      (cnt_reg < C_W'(ARRAY_COLS + gi) + C_W'(cols_reg));
         assign psum_valid[gi] = win && !stall;
         assign psum_addr[gi]  = win ? (pbase_reg + ADDR_W'(gi) * cols_a + cnt_a
                                        - ADDR_W'(ARRAY_COLS + gi)) : '0;
      end
   endgenerate

endmodule

// File: tb/tb_ws_tile_controller.sv
// Bench for ws_tile_controller: a schedule-queue reference model expands each
// accepted go into its list of non-stalled steps and predicts every output.
module tb_ws_tile_controller;

   localparam int R  = 3;
   localparam int C  = 3;
   localparam int VW = 1 + 1 + 32 + C + 32*C + R + 32*R + 1 + 16 + 1;

   logic        clk = 1'b0;
   logic        rst, go, stall;
   logic [15:0] iact_cols, num_tiles;
   logic [31:0] weight_base, iact_base, psum_base;
   logic        busy, load_weight, accumulate, done;
   logic [31:0] weight_addr;
   logic [C-1:0] load_iact;
   logic [31:0] iact_addr [C];
   logic [R-1:0] psum_valid;
   logic [31:0] psum_addr [R];
   logic [15:0] tile_idx;

   ws_tile_controller dut (
      .clk(clk), .rst(rst), .go(go), .iact_cols(iact_cols), .num_tiles(num_tiles),
      .weight_base(weight_base), .iact_base(iact_base), .psum_base(psum_base),
      .stall(stall), .busy(busy), .load_weight(load_weight), .weight_addr(weight_addr),
      .load_iact(load_iact), .iact_addr(iact_addr), .psum_valid(psum_valid),
      .psum_addr(psum_addr), .accumulate(accumulate), .tile_idx(tile_idx), .done(done)
   );

   always #5 clk = ~clk;

   // kind: 1 = weight load step, 2 = compute step, 3 = done step
   typedef struct {int kind; int tile; int k;} step_t;
   step_t       sched [$];
   int          m_cols, m_tiles, last_tile;
   logic [31:0] m_wb, m_ib, m_pb;
   logic [VW-1:0] exp_vec;
   int n_checks = 0;
   int n_fails  = 0;
   int cyc      = 0;

   function automatic logic [VW-1:0] pack(input logic b, input logic lw, input logic [31:0] wa,
         input logic [C-1:0] li, input logic [31:0] ia [C], input logic [R-1:0] pv,
         input logic [31:0] pa [R], input logic acc, input logic [15:0] ti, input logic dn);
      return {b, lw, wa, li, ia[0], ia[1], ia[2], pv, pa[0], pa[1], pa[2], acc, ti, dn};
   endfunction

   function automatic logic [VW-1:0] observed();
      return pack(busy, load_weight, weight_addr, load_iact, iact_addr, psum_valid,
                  psum_addr, accumulate, tile_idx, done);
   endfunction

   // Expected outputs for the step at the head of the schedule.
   function automatic logic [VW-1:0] model_exp();
      logic [31:0] ia [C];
      logic [31:0] pa [R];
      logic [C-1:0] li = '0;
      logic [R-1:0] pv = '0;
      logic b = 0, lw = 0, acc = 0, dn = 0;
      logic [31:0] wa = '0;
      logic [15:0] ti = 16'(last_tile);
      step_t s;
      for (int j = 0; j < C; j++) ia[j] = '0;
      for (int i = 0; i < R; i++) pa[i] = '0;
      if (sched.size() > 0) begin
         s   = sched[0];
         b   = 1;
         ti  = 16'(s.tile);
         acc = (s.tile != 0);
         dn  = (s.kind == 3);
         if (s.kind == 1) begin
            lw = !stall;
            wa = m_wb + 32'(s.tile * C + s.k);
         end
         if (s.kind == 2) begin
            for (int j = 0; j < C; j++)
               if (s.k >= j && s.k < j + m_cols) begin
                  li[j] = !stall;
                  ia[j] = m_ib + 32'(j * m_cols + s.k - j);
               end
            for (int i = 0; i < R; i++)
               if (s.k >= C + i && s.k < C + i + m_cols) begin
                  pv[i] = !stall;
                  pa[i] = m_pb + 32'(i * m_cols + s.k - C - i);
               end
         end
      end
      return pack(b, lw, wa, li, ia, pv, pa, acc, ti, dn);
   endfunction

   // Let inputs settle, then predict the current cycle.
   task automatic sample();
      #1;
      exp_vec = model_exp();
   endtask

   // Advance one clock; the model consumes the same inputs the DUT samples.
   task automatic adv();
      @(posedge clk);
      if (rst) begin
         sched.delete();
         last_tile = 0;
      end else if (sched.size() == 0) begin
         if (go) begin
            m_cols = int'(iact_cols); m_tiles = int'(num_tiles);
            m_wb = weight_base; m_ib = iact_base; m_pb = psum_base;
            last_tile = 0;
            if (m_cols == 0 || m_tiles == 0) begin
               sched.push_back('{3, 0, 0});
            end else begin
               for (int t = 0; t < m_tiles; t++) begin
                  for (int w = 0; w < C; w++) sched.push_back('{1, t, w});
                  for (int c = 0; c < m_cols + R + C; c++) sched.push_back('{2, t, c});
               end
               sched.push_back('{3, m_tiles - 1, 0});
            end
         end
      end else if (sched[0].kind == 3 || !stall) begin
         last_tile = sched[0].tile;
         void'(sched.pop_front());
      end
      @(negedge clk);
      cyc++;
   endtask

   task automatic set_cfg(input int cols, input int tiles, input logic [31:0] wb,
                          input logic [31:0] ib, input logic [31:0] pb);
      iact_cols = 16'(cols); num_tiles = 16'(tiles);
      weight_base = wb; iact_base = ib; psum_base = pb;
   endtask

   task automatic test_reset();
      rst = 1; go = 1; stall = 0;
      set_cfg(3, 1, 0, 0, 0);
      adv(); adv();
      rst = 0; go = 0;
      sample();
      n_checks++;
      if (observed() !== exp_vec) begin
         n_fails++; $display("FAIL reset_outputs cyc=%0d got=%h exp=%h", cyc, observed(), exp_vec);
      end
      adv(); sample();
      n_checks++;
      if (busy !== 1'b0) begin
         n_fails++; $display("FAIL reset_go_discarded cyc=%0d busy=%b exp=0", cyc, busy);
      end
   endtask

   task automatic test_basic();
      int done_at = -1;
      set_cfg(3, 1, 0, 0, 0);
      for (int t = 0; t < 18; t++) begin
         go = (t == 0);
         sample();
         n_checks++;
         if (observed() !== exp_vec) begin
            n_fails++; $display("FAIL basic_trace t=%0d got=%h exp=%h", t, observed(), exp_vec);
         end
         if (t == 6) begin
            n_checks++;
            if (load_iact[2] !== 1'b1 || iact_addr[2] !== 32'd6) begin
               n_fails++; $display("FAIL basic_iact2 t=%0d got=%b/%0d exp=1/6", t, load_iact[2], iact_addr[2]);
            end
         end
         if (done === 1'b1 && done_at < 0) done_at = t;
         adv();
      end
      go = 0;
      n_checks++;
      if (done_at != 1 + C + 3 + R + C) begin
         n_fails++; $display("FAIL basic_done_time got=%0d exp=%0d", done_at, 1 + C + 3 + R + C);
      end
   endtask

   task automatic test_multi_tile();
      int dones = 0;
      set_cfg($urandom_range(1, 4), 2, $urandom, $urandom, $urandom);
      for (int t = 0; t < 34; t++) begin
         go = (t == 0);
         sample();
         n_checks++;
         if (observed() !== exp_vec) begin
            n_fails++; $display("FAIL multi_trace t=%0d got=%h exp=%h", t, observed(), exp_vec);
         end
         if (done === 1'b1) dones++;
         adv();
      end
      go = 0;
      n_checks++;
      if (dones != 1) begin
         n_fails++; $display("FAIL multi_done_count got=%0d exp=1", dones);
      end
   endtask

   task automatic test_stall();
      int done_at = -1;
      set_cfg(3, 1, 0, 0, 0);
      for (int t = 0; t < 22; t++) begin
         go = (t == 0);
         stall = (t >= 8 && t <= 11);
         sample();
         n_checks++;
         if (observed() !== exp_vec) begin
            n_fails++; $display("FAIL stall_trace t=%0d got=%h exp=%h", t, observed(), exp_vec);
         end
         if (t == 9) begin
            n_checks++;
            if ({load_weight, load_iact, psum_valid} !== '0) begin
               n_fails++; $display("FAIL stall_strobes t=%0d got=%b exp=0", t, {load_weight, load_iact, psum_valid});
            end
         end
         if (done === 1'b1 && done_at < 0) done_at = t;
         adv();
      end
      go = 0; stall = 0;
      n_checks++;
      if (done_at != 17) begin
         n_fails++; $display("FAIL stall_done_time got=%0d exp=17", done_at);
      end
   endtask

   task automatic test_reset_mid();
      int dones = 0;
      set_cfg(3, 2, 32'h100, 32'h200, 32'h300);
      for (int t = 0; t < 11; t++) begin
         go = (t == 0);
         rst = (t == 9);
         sample();
         n_checks++;
         if (observed() !== exp_vec) begin
            n_fails++; $display("FAIL rstmid_trace t=%0d got=%h exp=%h", t, observed(), exp_vec);
         end
         if (t == 10) begin
            n_checks++;
            if (busy !== 1'b0 || tile_idx !== 16'd0) begin
               n_fails++; $display("FAIL rstmid_idle got=%b/%0d exp=0/0", busy, tile_idx);
            end
         end
         adv();
      end
      rst = 0;
      set_cfg(2, 1, 32'h40, 32'h50, 32'h60);
      for (int t = 0; t < 16; t++) begin
         go = (t == 0);
         sample();
         n_checks++;
         if (observed() !== exp_vec) begin
            n_fails++; $display("FAIL rstmid_rerun t=%0d got=%h exp=%h", t, observed(), exp_vec);
         end
         if (done === 1'b1) dones++;
         adv();
      end
      go = 0;
      n_checks++;
      if (dones != 1) begin
         n_fails++; $display("FAIL rstmid_done_count got=%0d exp=1", dones);
      end
   endtask

   task automatic test_zero();
      int done_at = -1;
      set_cfg(0, 2, 32'h10, 32'h20, 32'h30);
      for (int t = 0; t < 4; t++) begin
         go = (t == 0);
         sample();
         n_checks++;
         if (observed() !== exp_vec) begin
            n_fails++; $display("FAIL zero_trace t=%0d got=%h exp=%h", t, observed(), exp_vec);
         end
         if (done === 1'b1 && done_at < 0) done_at = t;
         adv();
      end
      go = 0;
      n_checks++;
      if (done_at != 1) begin
         n_fails++; $display("FAIL zero_done_time got=%0d exp=1", done_at);
      end
   endtask

   task automatic test_go_ignored();
      int dones = 0;
      set_cfg(3, 1, 0, 0, 0);
      for (int t = 0; t < 20; t++) begin
         go = (t == 0 || t == 6 || t == 7 || t == 13);
         sample();
         n_checks++;
         if (observed() !== exp_vec) begin
            n_fails++; $display("FAIL goign_trace t=%0d got=%h exp=%h", t, observed(), exp_vec);
         end
         if (done === 1'b1) dones++;
         adv();
      end
      go = 0;
      n_checks++;
      if (dones != 1) begin
         n_fails++; $display("FAIL goign_done_count got=%0d exp=1", dones);
      end
   endtask

   task automatic test_random();
      for (int run = 0; run < 25; run++) begin
         bit finished = 0;
         set_cfg($urandom_range(0, 5), $urandom_range(0, 3), $urandom, $urandom, $urandom);
         for (int t = 0; t < 200 && !finished; t++) begin
            go    = (t == 0) || ($urandom_range(0, 7) == 0);
            stall = ($urandom_range(0, 3) == 0);
            rst   = (t > 0) && ($urandom_range(0, 199) == 0);
            sample();
            n_checks++;
            if (observed() !== exp_vec) begin
               n_fails++; $display("FAIL random_trace run=%0d t=%0d got=%h exp=%h", run, t, observed(), exp_vec);
            end
            adv();
            if (t > 0 && sched.size() == 0) finished = 1;
         end
         go = 0; stall = 0; rst = 0;
         n_checks++;
         if (!finished) begin
            n_fails++; $display("FAIL random_timeout run=%0d busy=%b exp=idle", run, busy);
            rst = 1; adv(); rst = 0;
         end
      end
   endtask

   initial begin
      rst = 1; go = 0; stall = 0; last_tile = 0;
      m_cols = 0; m_tiles = 0; m_wb = '0; m_ib = '0; m_pb = '0;
      set_cfg(0, 0, 0, 0, 0);
      test_reset();
      test_basic();
      test_multi_tile();
      test_stall();
      test_reset_mid();
      test_zero();
      test_go_ignored();
      test_random();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
      $finish;
   end

endmodule
